// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, forward encodings and the register-hit helper for hazard_ctrl.
package hazard_pkg;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [4:0] REG_X0  = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       regwrite;
      logic       memread;
   } slot_t;

   function automatic logic hits(logic v, logic w, logic [4:0] rd, logic [4:0] r);
      return v && w && rd != REG_X0 && rd == r;
   endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the E-stage operand source for one register from the M and W shadow slots.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic       en_i,
   input  logic [4:0] src_i,
   input  logic       m_valid_i,
   input  logic [4:0] m_rd_i,
   input  logic       m_regwrite_i,
   input  logic       m_memread_i,
   input  logic       w_valid_i,
   input  logic [4:0] w_rd_i,
   input  logic       w_regwrite_i,
   output logic [1:0] sel_o
);
   logic m_hit, w_hit;
   always_comb begin
      m_hit = hits(m_valid_i, m_regwrite_i, m_rd_i, src_i) && !m_memread_i;
      w_hit = hits(w_valid_i, w_regwrite_i, w_rd_i, src_i);
      sel_o = !en_i ? FWD_RF : m_hit ? FWD_MEM : w_hit ? FWD_WB : FWD_RF;
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage core, driven by shadow copies of E, M, W.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_d_i,
   input  logic [4:0]       rs1_d_i,
   input  logic [4:0]       rs2_d_i,
   input  logic [4:0]       rd_d_i,
   input  logic             regwrite_d_i,
   input  logic             memread_d_i,
   input  logic             branch_taken_e_i,
   input  logic             mem_ready_i,
   output logic             stall_f_o,
   output logic             stall_d_o,
   output logic             flush_d_o,
   output logic             flush_e_o,
   output logic [1:0]       fwd_a_e_o,
   output logic [1:0]       fwd_b_e_o,
   output logic             fwd_a_d_o,
   output logic             fwd_b_d_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   slot_t            e_q, e_d;
   logic             m_valid_q, m_valid_d, m_regwrite_q, m_regwrite_d, m_memread_q, m_memread_d;
   logic [4:0]       m_rd_q, m_rd_d, w_rd_q, w_rd_d;
   logic             w_valid_q, w_valid_d, w_regwrite_q, w_regwrite_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             freeze, load_use, bubble;

   always_comb begin
      freeze    = !mem_ready_i;
      load_use  = valid_d_i && e_q.memread &&
                  (hits(e_q.valid, e_q.regwrite, e_q.rd, rs1_d_i) ||
                   hits(e_q.valid, e_q.regwrite, e_q.rd, rs2_d_i));
      bubble    = branch_taken_e_i || load_use;
      // freeze outranks branch, branch outranks load-use
      stall_f_o = freeze || (!branch_taken_e_i && load_use);
      stall_d_o = stall_f_o;
      flush_d_o = !freeze && branch_taken_e_i;
      flush_e_o = !freeze && bubble;
      fwd_a_d_o = hits(w_valid_q, w_regwrite_q, w_rd_q, rs1_d_i);
      fwd_b_d_o = hits(w_valid_q, w_regwrite_q, w_rd_q, rs2_d_i);
      e_d = freeze ? e_q : bubble ? slot_t'('0) :
            slot_t'{valid: valid_d_i, rd: rd_d_i, rs1: rs1_d_i, rs2: rs2_d_i,
                    regwrite: regwrite_d_i, memread: memread_d_i};
      m_valid_d    = freeze ? m_valid_q    : e_q.valid;
      m_rd_d       = freeze ? m_rd_q       : e_q.rd;
      m_regwrite_d = freeze ? m_regwrite_q : e_q.regwrite;
      m_memread_d  = freeze ? m_memread_q  : e_q.memread;
      w_valid_d    = freeze ? w_valid_q    : m_valid_q;
      w_rd_d       = freeze ? w_rd_q       : m_rd_q;
      w_regwrite_d = freeze ? w_regwrite_q : m_regwrite_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         e_q          <= '0;
         m_valid_q    <= 1'b0;
         m_rd_q       <= '0;
         m_regwrite_q <= 1'b0;
         m_memread_q  <= 1'b0;
         w_valid_q    <= 1'b0;
         w_rd_q       <= '0;
         w_regwrite_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         e_q          <= e_d;
         m_valid_q    <= m_valid_d;
         m_rd_q       <= m_rd_d;
         m_regwrite_q <= m_regwrite_d;
         m_memread_q  <= m_memread_d;
         w_valid_q    <= w_valid_d;
         w_rd_q       <= w_rd_d;
         w_regwrite_q <= w_regwrite_d;
         stall_cnt_q  <= stall_cnt_q + CNT_W'(stall_f_o);
         flush_cnt_q  <= flush_cnt_q + CNT_W'(flush_d_o);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

   hazard_fwd_sel u_fwd_a (
      .en_i(e_q.valid), .src_i(e_q.rs1),
      .m_valid_i(m_valid_q), .m_rd_i(m_rd_q), .m_regwrite_i(m_regwrite_q), .m_memread_i(m_memread_q),
      .w_valid_i(w_valid_q), .w_rd_i(w_rd_q), .w_regwrite_i(w_regwrite_q),
      .sel_o(fwd_a_e_o)
   );

   hazard_fwd_sel u_fwd_b (
      .en_i(e_q.valid), .src_i(e_q.rs2),
      .m_valid_i(m_valid_q), .m_rd_i(m_rd_q), .m_regwrite_i(m_regwrite_q), .m_memread_i(m_memread_q),
      .w_valid_i(w_valid_q), .w_rd_i(w_rd_q), .w_regwrite_i(w_regwrite_q),
      .sel_o(fwd_b_e_o)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random traffic against an instruction-level pipeline model.
module tb_hazard_ctrl;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        valid_d_i = 1'b0, regwrite_d_i = 1'b0, memread_d_i = 1'b0;
   logic [4:0]  rs1_d_i = '0, rs2_d_i = '0, rd_d_i = '0;
   logic        branch_taken_e_i = 1'b0, mem_ready_i = 1'b1;
   logic        stall_f_o, stall_d_o, flush_d_o, flush_e_o, fwd_a_d_o, fwd_b_d_o;
   logic [1:0]  fwd_a_e_o, fwd_b_e_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_d_i(valid_d_i), .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i),
      .rd_d_i(rd_d_i), .regwrite_d_i(regwrite_d_i), .memread_d_i(memread_d_i),
      .branch_taken_e_i(branch_taken_e_i), .mem_ready_i(mem_ready_i),
      .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
      .fwd_a_e_o(fwd_a_e_o), .fwd_b_e_o(fwd_b_e_o), .fwd_a_d_o(fwd_a_d_o), .fwd_b_d_o(fwd_b_d_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // An in-flight instruction as the model sees it; pipe[0]=E, pipe[1]=M, pipe[2]=W.
   typedef struct {bit v; int rd; int rs1; int rs2; bit wr; bit ld;} ins_t;
   ins_t pipe[3];
   int unsigned scnt, fcnt;
   bit exp_sf, exp_fd, exp_fe, exp_bub;
   int checks = 0, errors = 0;

   function automatic bit writes(ins_t s, int r);
      return s.v && s.wr && s.rd != 0 && s.rd == r;
   endfunction

   function automatic int src_of(int r);
      if (!pipe[0].v) return 0;
      if (writes(pipe[1], r) && !pipe[1].ld) return 2;
      if (writes(pipe[2], r)) return 1;
      return 0;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
      scnt = 0;
      fcnt = 0;
   endtask

   task automatic apply(int vd, int a, int b, int d, int w, int l, int br, int mr);
      bit lu;
      valid_d_i = vd[0]; rs1_d_i = a[4:0]; rs2_d_i = b[4:0]; rd_d_i = d[4:0];
      regwrite_d_i = w[0]; memread_d_i = l[0]; branch_taken_e_i = br[0]; mem_ready_i = mr[0];
      #1;
      lu = vd[0] && pipe[0].ld && (writes(pipe[0], a) || writes(pipe[0], b));
      exp_bub = br[0] || lu;
      exp_sf = !mr[0] || (!br[0] && lu);
      exp_fd = mr[0] && br[0];
      exp_fe = mr[0] && exp_bub;
      chk("stall_f", 32'(stall_f_o), 32'(exp_sf));
      chk("stall_d", 32'(stall_d_o), 32'(exp_sf));
      chk("flush_d", 32'(flush_d_o), 32'(exp_fd));
      chk("flush_e", 32'(flush_e_o), 32'(exp_fe));
      chk("fwd_a_e", 32'(fwd_a_e_o), 32'(src_of(pipe[0].rs1)));
      chk("fwd_b_e", 32'(fwd_b_e_o), 32'(src_of(pipe[0].rs2)));
      chk("fwd_a_d", 32'(fwd_a_d_o), 32'(writes(pipe[2], a)));
      chk("fwd_b_d", 32'(fwd_b_d_o), 32'(writes(pipe[2], b)));
      chk("stall_cnt", stall_cnt_o, scnt);
      chk("flush_cnt", flush_cnt_o, fcnt);
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (mem_ready_i) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = exp_bub ? '{0, 0, 0, 0, 0, 0} :
                   '{valid_d_i, int'(rd_d_i), int'(rs1_d_i), int'(rs2_d_i), regwrite_d_i, memread_d_i};
      end
      scnt += 32'(exp_sf);
      fcnt += 32'(exp_fd);
      #1;
   endtask

   task automatic do_reset();
      valid_d_i = 1'b0; branch_taken_e_i = 1'b0; mem_ready_i = 1'b1;
      rst_i = 1'b1;
      #1;
      clear_model();
      chk("rst_stall", 32'({stall_f_o, stall_d_o, flush_d_o, flush_e_o}), 0);
      chk("rst_fwd", 32'({fwd_a_e_o, fwd_b_e_o, fwd_a_d_o, fwd_b_d_o}), 0);
      chk("rst_cnt", stall_cnt_o | flush_cnt_o, 0);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   initial begin
      clear_model();
      do_reset();
      // back-to-back ALU: add x5; sub x6,x5,x1; consumer of x5
      apply(1, 1, 2, 5, 1, 0, 0, 1); tick();
      apply(1, 5, 1, 6, 1, 0, 0, 1); tick();
      apply(1, 5, 0, 10, 1, 0, 0, 1); chk("alu_mem_fwd", 32'(fwd_a_e_o), 32'b10); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 1); chk("alu_wb_fwd", 32'(fwd_a_e_o), 32'b01); tick();
      // load-use: lw x7; add x8,x7,x2
      do_reset();
      apply(1, 1, 0, 7, 1, 1, 0, 1); tick();
      apply(1, 7, 2, 8, 1, 0, 0, 1);
      chk("lu_stall", 32'({stall_f_o, stall_d_o, flush_e_o, flush_d_o}), 32'b1110); tick();
      apply(1, 7, 2, 8, 1, 0, 0, 1); chk("lu_once", 32'(stall_f_o), 0); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 1); chk("lu_fwd_wb", 32'(fwd_a_e_o), 32'b01);
      chk("lu_cnt", stall_cnt_o, 1); tick();
      // branch coinciding with load-use
      do_reset();
      apply(1, 1, 0, 7, 1, 1, 0, 1); tick();
      apply(1, 7, 2, 8, 1, 0, 1, 1);
      chk("br_ctl", 32'({stall_f_o, stall_d_o, flush_d_o, flush_e_o}), 32'b0011); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 1); chk("br_cnt", flush_cnt_o, 1); tick();
      // memory freeze for 3 cycles with a pending M forward
      do_reset();
      apply(1, 1, 2, 5, 1, 0, 0, 1); tick();
      apply(1, 5, 1, 6, 1, 0, 0, 1); tick();
      for (int i = 0; i < 3; i++) begin
         apply(1, 5, 5, 9, 1, 1, 1, 0);
         chk("frz_stall", 32'(stall_f_o), 1);
         chk("frz_fwd", 32'(fwd_a_e_o), 32'b10);
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      chk("frz_cnt", stall_cnt_o, 3);
      chk("frz_hold", 32'(fwd_a_e_o), 32'b10); tick();
      // x0 destination never stalls or forwards
      do_reset();
      apply(1, 1, 0, 0, 1, 1, 0, 1); tick();
      apply(1, 0, 0, 9, 1, 0, 0, 1); chk("x0_nostall", 32'(stall_f_o), 0); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 1); chk("x0_fwd", 32'({fwd_a_e_o, fwd_b_e_o}), 0); tick();
      // W-to-D bypass, then reset during a pending load-use stall
      do_reset();
      apply(1, 1, 2, 3, 1, 0, 0, 1); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 1); tick();
      apply(1, 1, 0, 4, 1, 1, 0, 1); tick();
      apply(1, 4, 3, 11, 1, 0, 0, 1);
      chk("byp_b_d", 32'(fwd_b_d_o), 1);
      chk("byp_lu", 32'(stall_f_o), 1);
      do_reset();
      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         else begin
            apply(int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 6) == 0), int'($urandom_range(0, 6) != 0));
            tick();
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (F, D, E, M, W).
- Keeps shadow copies of the register-use fields of the instructions in E, M and W.
- From these it drives the stall, flush and forward-select signals for the fetch, fd_regs, decode and execute stages.
- Also counts stall and flush cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- valid_d_i  input  1  D holds a real instruction (not a bubble).
- rs1_d_i  input  5  source register 1 of the instruction in D.
- rs2_d_i  input  5  source register 2 of the instruction in D.
- rd_d_i  input  5  destination register of the instruction in D.
- regwrite_d_i  input  1  D instruction writes the register file.
- memread_d_i  input  1  D instruction is a load.
- branch_taken_e_i  input  1  branch or jump resolved taken in E this cycle.
- mem_ready_i  input  1  data memory ready; 0 freezes the whole pipeline.
- stall_f_o  output  1  hold the PC.
- stall_d_o  output  1  hold the fd register.
- flush_d_o  output  1  clear the fd register to NOP.
- flush_e_o  output  1  insert a bubble into the D/E register.
- fwd_a_e_o  output  2  operand A source for E: 00 = register file, 01 = W result, 10 = M ALU output.
- fwd_b_e_o  output  2  operand B source for E, same encoding.
- fwd_a_d_o  output  1  bypass the W result into the D read of rs1.
- fwd_b_d_o  output  1  bypass the W result into the D read of rs2.
- stall_cnt_o  output  CNT_W  count of cycles with stall_f_o=1.
- flush_cnt_o  output  CNT_W  count of cycles with flush_d_o=1.

Behaviour:
- Shadow state:
  - E slot: valid, rd, rs1, rs2, regwrite, memread.
  - M slot: valid, rd, regwrite, memread.
  - W slot: valid, rd, regwrite.
  - Reset clears all valid bits and fields to 0. Both counters reset to 0.
- Reset output values: every control output is combinational from state and inputs. With all slots invalid and idle inputs, all outputs are 0.
- Hit definition: a slot X "hits" register r when X.valid, X.regwrite, X.rd != 0 and X.rd == r. Register x0 is never forwarded, stalled on, or bypassed.
- Load-use condition: valid_d_i, E.memread, and E hits rs1_d_i or rs2_d_i.
- Signal priority, evaluated each cycle:
  1. mem_ready_i = 0 (freeze):
     - stall_f_o = stall_d_o = 1; flush_d_o = flush_e_o = 0.
     - All shadow slots hold.
     - This wins over branch and load-use; those are re-evaluated once mem_ready_i returns to 1.
  2. branch_taken_e_i = 1:
     - flush_d_o = flush_e_o = 1; stall_f_o = stall_d_o = 0.
     - Shadow update: E <= bubble, M <= E, W <= M.
     - A branch that coincides with a load-use condition suppresses the load-use stall.
  3. Load-use:
     - stall_f_o = stall_d_o = 1; flush_e_o = 1; flush_d_o = 0.
     - Shadow update: E <= bubble, M <= E, W <= M.
     - Exactly one stall cycle per load-use pair; the consumer then forwards from W.
  4. Otherwise:
     - All control outputs = 0.
     - Shadow update: E <= D fields (valid = valid_d_i), M <= E, W <= M.
- E-stage forwarding (fwd_a_e_o for E.rs1, fwd_b_e_o for E.rs2, evaluated only when E.valid):
  - 10 when M hits the register and !M.memread.
  - Else 01 when W hits the register.
  - Else 00.
  - M has priority over W when both hit the same register.
- D-stage bypass: fwd_a_d_o = W hits rs1_d_i; fwd_b_d_o = W hits rs2_d_i. This covers the write-at-posedge / asynchronous-read window of the register file.
- Counters:
  - stall_cnt_o increments on every clock edge where stall_f_o = 1, including freeze and load-use.
  - flush_cnt_o increments where flush_d_o = 1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation: asserting rst_i clears all shadow slots and both counters immediately. Control outputs then follow the cleared state; no pending stall survives reset.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd encodings: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - A packed struct for a shadow slot (valid, rd, rs1, rs2, regwrite, memread).
  - REG_X0 = 5'd0.
- One sub-module, hazard_fwd_sel: combinational compare of one source register against the M and W slots, returning the 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- Back-to-back ALU ops: add x5 (D) followed by sub x6,x5,x1 -> when sub reaches E, fwd_a_e_o = 10. One cycle later an instruction reading x5 in E gets 01.
- Load-use: lw x7 in E, add x8,x7,x2 in D -> one cycle of stall_f_o = stall_d_o = flush_e_o = 1. Next cycle add in E with fwd_a_e_o = 01. stall_cnt_o = 1.
- Branch over load-use: branch_taken_e_i = 1 in the same cycle as a load-use condition -> flush_d_o = flush_e_o = 1, stall_f_o = 0, flush_cnt_o = 1.
- Memory freeze: mem_ready_i = 0 for 3 cycles during a pending forward -> stall_f_o = 1 for all three, shadow unchanged, forward select unchanged, stall_cnt_o = 3.
- x0 destination: lw x0 then add x9,x0,x0 -> no stall, all fwd = 00.
- W-to-D bypass and reset: W writes x3 while D reads rs2 = x3 -> fwd_b_d_o = 1. Then assert rst_i mid-stream -> all outputs and counters 0 within the same cycle.
